rggen_bus_initiator: RTL and testbench

RGGEN_BUS_INITIATOR -- requirements
Module: rggen_bus_initiator

---
 rtl/rggen_bus_initiator.sv | 189 ++++++++++++++++++
 tb/tb_rggen_bus_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_bus_initiator.sv
// Register bus initiator: turns a valid/ready request into one register bus
// cycle and returns a single status/read-data response.
// Optional feature macro: RGGEN_BUS_INITIATOR_TIMEOUT_EN adds an ACCESS watchdog
// that gives up after TIMEOUT_CYCLES cycles without i_register_ready.
module rggen_bus_initiator #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_request_valid,
  output logic                     o_request_ready,
  input  logic [1:0]               i_request_access,
  input  logic [ADDRESS_WIDTH-1:0] i_request_address,
  input  logic [BUS_WIDTH-1:0]     i_request_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_request_strobe,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic [1:0]               o_response_status,
  output logic [BUS_WIDTH-1:0]     o_response_read_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_active,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int unsigned STRB_W = BUS_WIDTH / 8;
  localparam int unsigned LSB_W  = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((2 ** LSB_W) - 1);
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     req_ready_q, req_ready_d;
  logic                     reg_valid_q, reg_valid_d;
  logic [1:0]               reg_access_q, reg_access_d;
  logic [ADDRESS_WIDTH-1:0] reg_address_q, reg_address_d;
  logic [BUS_WIDTH-1:0]     reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]        reg_strobe_q, reg_strobe_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic [BUS_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                     handshake_c;
  logic                     is_read_c;

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] count_q, count_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  assign handshake_c = i_request_valid && req_ready_q;
  assign is_read_c   = !reg_access_q[0];

  // State and output registers, cleared synchronously
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      reg_valid_q   <= 1'b0;
      reg_access_q  <= 2'b00;
      reg_address_q <= '0;
      reg_wdata_q   <= '0;
      reg_strobe_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= 2'b00;
      rsp_rdata_q   <= '0;
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      reg_valid_q   <= reg_valid_d;
      reg_access_q  <= reg_access_d;
      reg_address_q <= reg_address_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_strobe_q  <= reg_strobe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_rdata_q   <= rsp_rdata_d;
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
      count_q       <= count_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    reg_valid_d   = reg_valid_q;
    reg_access_d  = reg_access_q;
    reg_address_d = reg_address_q;
    reg_wdata_d   = reg_wdata_q;
    reg_strobe_d  = reg_strobe_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_rdata_d   = rsp_rdata_q;
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
    count_d       = count_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (handshake_c) begin
          req_ready_d   = 1'b0;
          reg_access_d  = i_request_access;
          reg_address_d = i_request_address & ADDR_MASK;
          reg_wdata_d   = i_request_write_data;
          reg_strobe_d  = i_request_access[0] ? i_request_strobe : '0;
          if (i_request_access != 2'b00) begin
            state_d     = ACCESS;
            reg_valid_d = 1'b1;
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
            count_d     = '0;
`endif
          end else begin
            // No bus cycle for an undefined access; answer with an error
            state_d      = RESPONSE;
            rsp_valid_d  = 1'b1;
            rsp_status_d = STATUS_SLVERR;
            rsp_rdata_d  = '0;
          end
        end
      end
      ACCESS: begin
        if (i_register_ready) begin
          state_d     = RESPONSE;
          reg_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          if (i_register_active) begin
            rsp_status_d = i_register_status;
            rsp_rdata_d  = is_read_c ? i_register_read_data : '0;
          end else begin
            rsp_status_d = STATUS_DECERR;
            rsp_rdata_d  = '0;
          end
        end
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
        else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESPONSE;
          reg_valid_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STATUS_SLVERR;
          rsp_rdata_d  = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
`endif
      end
      RESPONSE: begin
        if (i_response_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_request_ready       = req_ready_q;
  assign o_register_valid      = reg_valid_q;
  assign o_register_access     = reg_access_q;
  assign o_register_address    = reg_address_q;
  assign o_register_write_data = reg_wdata_q;
  assign o_register_strobe     = reg_strobe_q;
  assign o_response_valid      = rsp_valid_q;
  assign o_response_status     = rsp_status_q;
  assign o_response_read_data  = rsp_rdata_q;

endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Directed bench for rggen_bus_initiator: table of transactions plus
// hand-written reset and watchdog sequences.
module tb_rggen_bus_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_request_valid;
  logic        o_request_ready;
  logic [1:0]  i_request_access;
  logic [7:0]  i_request_address;
  logic [31:0] i_request_write_data;
  logic [3:0]  i_request_strobe;
  logic        o_response_valid;
  logic        i_response_ready;
  logic [1:0]  o_response_status;
  logic [31:0] o_response_read_data;
  logic        o_register_valid;
  logic [1:0]  o_register_access;
  logic [7:0]  o_register_address;
  logic [31:0] o_register_write_data;
  logic [3:0]  o_register_strobe;
  logic        i_register_active;
  logic        i_register_ready;
  logic [1:0]  i_register_status;
  logic [31:0] i_register_read_data;

  int checks = 0;
  int errors = 0;

  rggen_bus_initiator #(
    .ADDRESS_WIDTH  (8),
    .BUS_WIDTH      (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_request_valid       (i_request_valid),
    .o_request_ready       (o_request_ready),
    .i_request_access      (i_request_access),
    .i_request_address     (i_request_address),
    .i_request_write_data  (i_request_write_data),
    .i_request_strobe      (i_request_strobe),
    .o_response_valid      (o_response_valid),
    .i_response_ready      (i_response_ready),
    .o_response_status     (o_response_status),
    .o_response_read_data  (o_response_read_data),
    .o_register_valid      (o_register_valid),
    .o_register_access     (o_register_access),
    .o_register_address    (o_register_address),
    .o_register_write_data (o_register_write_data),
    .o_register_strobe     (o_register_strobe),
    .i_register_active     (i_register_active),
    .i_register_ready      (i_register_ready),
    .i_register_status     (i_register_status),
    .i_register_read_data  (i_register_read_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        active;
    logic [1:0]  rstat;
    logic [31:0] rdata;
    int          resp_waits;
    logic        bus;
    logic [7:0]  e_addr;
    logic [3:0]  e_strb;
    logic [1:0]  e_stat;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // One complete transaction from request handshake to response handshake
  task automatic run_vec(input vec_t v, input int idx);
    i_request_valid      = 1'b1;
    i_request_access     = v.acc;
    i_request_address    = v.addr;
    i_request_write_data = v.wdata;
    i_request_strobe     = v.strb;
    tick();
    i_request_valid = 1'b0;
    chk($sformatf("v%0d_req_ready_busy", idx), o_request_ready, 1'b0);
    if (v.bus) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk($sformatf("v%0d_c%0d_reg_valid", idx, w), o_register_valid, 1'b1);
        chk($sformatf("v%0d_c%0d_reg_addr", idx, w), o_register_address, v.e_addr);
        chk($sformatf("v%0d_c%0d_reg_strb", idx, w), o_register_strobe, v.e_strb);
        chk($sformatf("v%0d_c%0d_reg_acc", idx, w), o_register_access, v.acc);
        chk($sformatf("v%0d_c%0d_reg_wdata", idx, w), o_register_write_data, v.wdata);
        chk($sformatf("v%0d_c%0d_rsp_valid_early", idx, w), o_response_valid, 1'b0);
        if (w == v.waits) begin
          i_register_ready     = 1'b1;
          i_register_active    = v.active;
          i_register_status    = v.rstat;
          i_register_read_data = v.rdata;
        end
        tick();
      end
      i_register_ready     = 1'b0;
      i_register_active    = 1'b0;
      i_register_status    = 2'b00;
      i_register_read_data = 32'h0;
    end
    chk($sformatf("v%0d_reg_valid_off", idx), o_register_valid, 1'b0);
    for (int w = 0; w <= v.resp_waits; w++) begin
      chk($sformatf("v%0d_r%0d_rsp_valid", idx, w), o_response_valid, 1'b1);
      chk($sformatf("v%0d_r%0d_rsp_status", idx, w), o_response_status, v.e_stat);
      chk($sformatf("v%0d_r%0d_rsp_data", idx, w), o_response_read_data, v.e_data);
      chk($sformatf("v%0d_r%0d_req_ready", idx, w), o_request_ready, 1'b0);
      if (w == v.resp_waits) i_response_ready = 1'b1;
      tick();
    end
    i_response_ready = 1'b0;
    chk($sformatf("v%0d_rsp_valid_done", idx), o_response_valid, 1'b0);
    chk($sformatf("v%0d_req_ready_idle", idx), o_request_ready, 1'b1);
  endtask

  initial begin
    //           acc    addr   wdata         strb   wt act  rst    rdata        rw bus  eaddr  estrb  estat  edata
    vecs[0] = '{2'b10, 8'h14, 32'h00000000, 4'hF, 0, 1'b1, 2'b00, 32'hCAFE0001, 0, 1'b1, 8'h14, 4'h0, 2'b00, 32'hCAFE0001};
    vecs[1] = '{2'b11, 8'h17, 32'h12345678, 4'h3, 3, 1'b1, 2'b00, 32'hDEADBEEF, 0, 1'b1, 8'h14, 4'h3, 2'b00, 32'h00000000};
    vecs[2] = '{2'b01, 8'h2A, 32'hA5A5A5A5, 4'hC, 1, 1'b1, 2'b01, 32'h11111111, 0, 1'b1, 8'h28, 4'hC, 2'b01, 32'h00000000};
    vecs[3] = '{2'b10, 8'h3F, 32'h00000000, 4'h0, 0, 1'b0, 2'b00, 32'h12345678, 0, 1'b1, 8'h3C, 4'h0, 2'b11, 32'h00000000};
    vecs[4] = '{2'b00, 8'h10, 32'h55555555, 4'hF, 0, 1'b1, 2'b00, 32'h00000000, 0, 1'b0, 8'h10, 4'h0, 2'b10, 32'h00000000};
    vecs[5] = '{2'b10, 8'hFF, 32'h00000000, 4'h0, 2, 1'b1, 2'b10, 32'hBAD0BAD0, 5, 1'b1, 8'hFC, 4'h0, 2'b10, 32'hBAD0BAD0};
    vecs[6] = '{2'b11, 8'h01, 32'h0F0F0F0F, 4'hF, 0, 1'b1, 2'b11, 32'h77777777, 0, 1'b1, 8'h00, 4'hF, 2'b11, 32'h00000000};

    i_rst                = 1'b1;
    i_request_valid      = 1'b0;
    i_request_access     = 2'b00;
    i_request_address    = 8'h0;
    i_request_write_data = 32'h0;
    i_request_strobe     = 4'h0;
    i_response_ready     = 1'b0;
    i_register_active    = 1'b0;
    i_register_ready     = 1'b0;
    i_register_status    = 2'b00;
    i_register_read_data = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", o_request_ready, 1'b0);
    chk("rst_reg_valid", o_register_valid, 1'b0);
    chk("rst_rsp_valid", o_response_valid, 1'b0);
    chk("rst_reg_addr", o_register_address, 8'h00);
    chk("rst_rsp_status", o_response_status, 2'b00);
    chk("rst_rsp_data", o_response_read_data, 32'h0);
    i_rst = 1'b0;
    tick();
    chk("rel_req_ready", o_request_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset pulsed while the bus cycle is outstanding
    i_request_valid      = 1'b1;
    i_request_access     = 2'b11;
    i_request_address    = 8'h20;
    i_request_write_data = 32'h01020304;
    i_request_strobe     = 4'hF;
    tick();
    i_request_valid = 1'b0;
    chk("mid_reg_valid", o_register_valid, 1'b1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst_reg_valid", o_register_valid, 1'b0);
    chk("mid_rst_rsp_valid", o_response_valid, 1'b0);
    chk("mid_rst_req_ready", o_request_ready, 1'b0);
    i_rst            = 1'b0;
    i_register_ready = 1'b1;
    i_register_active = 1'b1;
    tick();
    chk("mid_rel_req_ready", o_request_ready, 1'b1);
    chk("mid_rel_rsp_valid", o_response_valid, 1'b0);
    tick();
    i_register_ready  = 1'b0;
    i_register_active = 1'b0;
    chk("mid_late_rsp_valid", o_response_valid, 1'b0);
    chk("mid_late_reg_valid", o_register_valid, 1'b0);

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
    // Watchdog expiry: four ACCESS cycles, then an error response
    i_request_valid   = 1'b1;
    i_request_access  = 2'b10;
    i_request_address = 8'h08;
    tick();
    i_request_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_c%0d_reg_valid", c), o_register_valid, 1'b1);
      tick();
    end
    chk("to_reg_valid_off", o_register_valid, 1'b0);
    chk("to_rsp_valid", o_response_valid, 1'b1);
    chk("to_rsp_status", o_response_status, 2'b10);
    chk("to_rsp_data", o_response_read_data, 32'h0);
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;

    // Ready in the expiry cycle wins over the watchdog
    i_request_valid   = 1'b1;
    i_request_access  = 2'b10;
    i_request_address = 8'h0C;
    tick();
    i_request_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("tr_c%0d_reg_valid", c), o_register_valid, 1'b1);
      if (c == 3) begin
        i_register_ready     = 1'b1;
        i_register_active    = 1'b1;
        i_register_status    = 2'b00;
        i_register_read_data = 32'h0BADF00D;
      end
      tick();
    end
    i_register_ready  = 1'b0;
    i_register_active = 1'b0;
    chk("tr_rsp_valid", o_response_valid, 1'b1);
    chk("tr_rsp_status", o_response_status, 2'b00);
    chk("tr_rsp_data", o_response_read_data, 32'h0BADF00D);
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;
    chk("tr_req_ready", o_request_ready, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
